load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle load/store engine between the register file and the data-memory bus.
//  Takes base address (reg1) and store data (reg2) read from the register file.
//  Runs one request/acknowledge transaction on the memory bus.
//  For loads, drives the register file write port (writeEn/writeAddr/writeData) for exactly one cycle.
// PARAMETERS
//  DATA_WIDTH   8   width of register and memory data words
//  MEM_AW       8   memory address width; equals DATA_WIDTH in this CPU
//  REG_COUNT    16  register file depth; REG_AW = $clog2(REG_COUNT)
//  TIMEOUT      64  max cycles spent waiting for memAck before fault; 0 = wait forever
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous active-low reset
//  start        in   1           one-cycle request pulse; sampled only while busy=0
//  isLoad       in   1           1 = load, 0 = store; sampled with start
//  rd           in   REG_AW      load destination register; sampled with start
//  baseAddr     in   DATA_WIDTH  address operand (reg1 of register file)
//  storeData    in   DATA_WIDTH  store operand (reg2 of register file)
//  memReq       out  1           bus request, held until acknowledged
//  memWe        out  1           1 = write cycle; valid while memReq=1
//  memAddr      out  MEM_AW      latched address
//  memWData     out  DATA_WIDTH  latched store data
//  memAck       in   1           bus acknowledge; memRData valid in the same cycle
//  memRData     in   DATA_WIDTH  load data
//  regWriteEn   out  1           register file write strobe, one cycle per load
//  regWriteAddr out  REG_AW      register file write address
//  regWriteData out  DATA_WIDTH  register file write data
//  busy         out  1           high in any state other than IDLE
//  done         out  1           one-cycle completion pulse
//  fault        out  1           one-cycle timeout pulse
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; every output and internal register = 0. Takes effect immediately,
//   including mid-transaction: memReq drops without waiting for the clock; no write and no done are issued.
//  States: IDLE, REQ, WB, FIN. All outputs are decoded from registered state and latches (Moore).
//  IDLE: busy=0. When start=1, latch isLoad, rd, baseAddr and storeData, clear the wait counter, go to REQ.
//  REQ: memReq=1, memWe=~isLoad, memAddr and memWData come from the latches.
//   memAck=1 on a load: capture memRData and go to WB.
//   memAck=1 on a store: go to FIN.
//   No ack: increment the wait counter. When TIMEOUT!=0 and counter==TIMEOUT-1, pulse fault for one cycle
//    and go to IDLE; memReq drops; no write and no done are issued.
//   memAck and the timeout in the same cycle: the ack wins.
//  WB: regWriteEn=1, regWriteAddr=latched rd, regWriteData=captured data, done=1. Go to IDLE.
//  FIN: done=1, regWriteEn=0. Go to IDLE.
//  Latency: start at cycle t; memReq from t+1; ack at t+k (k>=1); done and write at t+k+1; busy=0 at t+k+2.
//  Back-to-back: the earliest next start is accepted in the cycle busy=0 (IDLE), so the minimum period is 3 cycles.
//  start while busy=1 is ignored, not queued. memAck while memReq=0 is ignored.
//  regWriteEn asserts only for loads, exactly once per completed load. rd=0 is written like any other register.
//  Address/data are plain latched copies: no arithmetic, no wrap-around. The wait counter is $clog2(TIMEOUT+1)
//   bits and saturates when TIMEOUT=0.
// STRUCTURE
//  cpu_defs.vh (shared include): DATA_WIDTH and REG_COUNT defaults; LSU state encodings
//   LSU_IDLE=2'd0, LSU_REQ=2'd1, LSU_WB=2'd2, LSU_FIN=2'd3.
//  Sub-module lsu_timeout: clear/enable wait counter with an `expired` output; TIMEOUT passed through.
//  The rest is flat: state register, operand latches, capture register, output decode.
// TESTING
//  1 Load: rd=3, baseAddr=0x40, memAck 2 cycles after memReq with memRData=0xA5
//    -> memAddr=0x40, memWe=0; next cycle regWriteEn=1, regWriteAddr=3, regWriteData=0xA5, done=1.
//  2 Store: baseAddr=0x10, storeData=0x5A, ack on the first REQ cycle
//    -> memWe=1, memWData=0x5A for 1 cycle; done=1 next cycle; regWriteEn stays 0.
//  3 TIMEOUT=4, memAck never asserted -> memReq high 4 cycles, then fault=1 for 1 cycle;
//    done=0, regWriteEn=0, busy=0 after.
//  4 start pulsed again while busy (different rd/addr) -> ignored; first transaction completes unchanged;
//    a start issued when busy=0 is then accepted.
//  5 rst_n low while in REQ -> memReq, busy and done go to 0 asynchronously; after release,
//    a late memAck=1 produces no write.
//  6 memAck together with the timeout in the final wait cycle (TIMEOUT=4, ack on the 4th cycle, load)
//    -> write and done occur; fault stays 0.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared widths and LSU state encodings
package load_store_unit_pkg;
  localparam int LSU_DATA_WIDTH = 8;
  localparam int LSU_REG_COUNT  = 16;
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WB   = 2'd2,
    LSU_FIN  = 2'd3
  } lsu_state_e;
endpackage

// File: rtl/lsu_timeout.sv
// lsu_timeout: wait-cycle counter that flags the last permitted cycle; saturates when TIMEOUT=0
module lsu_timeout #(
  parameter int TIMEOUT = 64,
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CW-1:0] cnt_q, cnt_d;
  // next count: clear wins, otherwise count up without wrapping
  always_comb cnt_d = clr ? '0 : (en && cnt_q != '1) ? cnt_q + CW'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one req/ack memory transaction per start, with register writeback for loads
module load_store_unit import load_store_unit_pkg::*; #(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int MEM_AW     = DATA_WIDTH,
  parameter int REG_COUNT  = LSU_REG_COUNT,
  parameter int TIMEOUT    = 64,
  localparam int REG_AW    = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  isLoad,
  input  logic [REG_AW-1:0]     rd,
  input  logic [DATA_WIDTH-1:0] baseAddr,
  input  logic [DATA_WIDTH-1:0] storeData,
  output logic                  memReq,
  output logic                  memWe,
  output logic [MEM_AW-1:0]     memAddr,
  output logic [DATA_WIDTH-1:0] memWData,
  input  logic                  memAck,
  input  logic [DATA_WIDTH-1:0] memRData,
  output logic                  regWriteEn,
  output logic [REG_AW-1:0]     regWriteAddr,
  output logic [DATA_WIDTH-1:0] regWriteData,
  output logic                  busy,
  output logic                  done,
  output logic                  fault
);
  lsu_state_e            state_q, state_d;
  logic                  is_load_q, is_load_d;
  logic [REG_AW-1:0]     rd_q, rd_d;
  logic [MEM_AW-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  fault_q, fault_d;
  logic                  expired;
  lsu_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == LSU_IDLE),
    .en      (state_q == LSU_REQ && !memAck),
    .expired (expired)
  );
  // next state, operand latches and load capture; an ack beats a same-cycle timeout
  always_comb begin
    state_d   = state_q;
    is_load_d = is_load_q;
    rd_d      = rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    fault_d   = 1'b0;
    if (state_q == LSU_IDLE && start) begin
      is_load_d = isLoad;
      rd_d      = rd;
      addr_d    = MEM_AW'(baseAddr);
      wdata_d   = storeData;
      state_d   = LSU_REQ;
    end else if (state_q == LSU_REQ) begin
      if (memAck) begin
        state_d = is_load_q ? LSU_WB : LSU_FIN;
        rdata_d = is_load_q ? memRData : rdata_q;
      end else if (expired) begin
        fault_d = 1'b1;
        state_d = LSU_IDLE;
      end
    end else if (state_q != LSU_IDLE) begin
      state_d = LSU_IDLE;
    end
  end
  // state and datapath registers, all cleared by async reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= LSU_IDLE;
      is_load_q <= 1'b0;
      rd_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_load_q <= is_load_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      fault_q   <= fault_d;
    end
  assign memReq       = state_q == LSU_REQ;
  assign memWe        = memReq && !is_load_q;
  assign memAddr      = addr_q;
  assign memWData     = wdata_q;
  assign regWriteEn   = state_q == LSU_WB;
  assign regWriteAddr = rd_q;
  assign regWriteData = rdata_q;
  assign busy         = state_q != LSU_IDLE;
  assign done         = state_q == LSU_WB || state_q == LSU_FIN;
  assign fault        = fault_q;
endmodule
